// File: rtl/scroll_wave_if.sv
// Sample-in / pixel-out bundle for scroll_wave_buffer.
// master = sample producer and pixel consumer, slave = the buffer itself.
interface scroll_wave_if #(
  parameter int AMP_WIDTH = 31
);
  // Handshake: a sample transfers on a rising clk edge where sample_valid and
  // sample_ready are both high. sample holds steady while valid waits for ready.
  // pixel_valid has no back-pressure; x, y, pixel_color and done qualify with it.
  logic [AMP_WIDTH-1:0] sample;
  logic                 sample_valid;
  logic                 sample_ready;
  logic [10:0]          x;
  logic [10:0]          y;
  logic                 pixel_color;
  logic                 pixel_valid;
  logic                 done;

  modport master (
    output sample, sample_valid,
    input  sample_ready, x, y, pixel_color, pixel_valid, done
  );

  modport slave (
    input  sample, sample_valid,
    output sample_ready, x, y, pixel_color, pixel_valid, done
  );
endinterface

// File: rtl/scroll_wave_buffer.sv
// Scrolling amplitude display: one column height per tick in a circular column memory,
// full-screen raster after each tick. Optional macro SCROLL_CENTER_LINE_EN draws the zero axis.
module scroll_wave_buffer #(
  parameter int H_PIXELS        = 640,
  parameter int V_PIXELS        = 480,
  parameter int AMP_WIDTH       = 31,
  parameter int AMP_SHIFT       = 20,
  parameter int CLK_HZ          = 50000000,
  parameter int SAMPLES_PER_SEC = 10
) (
  input  logic         clk,
  input  logic         reset,
  scroll_wave_if.slave bus,
  output logic [1:0]   state_dbg
);
  localparam int TICK_CYCLES = CLK_HZ / SAMPLES_PER_SEC;
  localparam int C  = V_PIXELS / 2;
  localparam int AW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int HW = $clog2(C + 1);
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [1:0] S_CLEAR  = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_DRAW   = 2'd3;

  logic [1:0]           state;
  logic [HW-1:0]        mem [H_PIXELS];
  logic [HW-1:0]        rd_half;
  logic [AW-1:0]        wptr;
  logic [TW-1:0]        tick_cnt;
  logic                 tick_pending;
  logic [AMP_WIDTH-1:0] hold;
  logic                 hold_full;

  // Raster issue position and the stage aligned with the registered memory read.
  logic [10:0] cx, cy;
  logic [10:0] s1_x, s1_y;
  logic        s1_valid, s1_last, s1_draw;

  logic                 raster_step, last_pix, accept;
  logic [11:0]          addr_sum;
  logic [AW-1:0]        raddr;
  logic [AMP_WIDTH-1:0] shifted;
  logic [HW-1:0]        half_new;
  logic [11:0]          y_ext, h_ext;
  logic                 lit_body, lit;

  assign state_dbg        = state;
  assign bus.sample_ready = !hold_full && (state != S_CLEAR);
  assign accept           = bus.sample_valid && bus.sample_ready;

  // Stop issuing once the final pixel sits in stage 1 so the counter wrap is not re-read.
  assign raster_step = ((state == S_CLEAR) || (state == S_DRAW)) && !s1_last;
  assign last_pix    = (cx == 11'(H_PIXELS - 1)) && (cy == 11'(V_PIXELS - 1));

  // Newest column lives at wptr-1, so screen x maps to (wptr-1-x) mod H_PIXELS.
  assign addr_sum = 12'(wptr) + 12'(H_PIXELS - 1) - 12'(cx);
  assign raddr    = (addr_sum >= 12'(H_PIXELS)) ? AW'(addr_sum - 12'(H_PIXELS)) : AW'(addr_sum);

  assign shifted  = hold >> AMP_SHIFT;
  assign half_new = !hold_full ? '0 :
                    (shifted > AMP_WIDTH'(C)) ? HW'(C) : HW'(shifted);

  assign y_ext    = 12'(s1_y);
  assign h_ext    = 12'(rd_half);
  assign lit_body = (rd_half != '0) && (y_ext + h_ext >= 12'(C)) && (y_ext < 12'(C) + h_ext);
`ifdef SCROLL_CENTER_LINE_EN
  assign lit = s1_draw && (lit_body || (s1_y == 11'(C)));
`else
  assign lit = s1_draw && lit_body;
`endif

  // Column memory: cleared column by column on row 0 of CLEAR, one write per COMMIT.
  always_ff @(posedge clk) begin
    if (state == S_COMMIT) begin
      mem[wptr] <= half_new;
    end else if ((state == S_CLEAR) && raster_step && (cy == 11'd0)) begin
      mem[AW'(cx)] <= '0;
    end
    rd_half <= mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_CLEAR;
      wptr            <= '0;
      tick_cnt        <= '0;
      tick_pending    <= 1'b0;
      hold            <= '0;
      hold_full       <= 1'b0;
      cx              <= '0;
      cy              <= '0;
      s1_x            <= '0;
      s1_y            <= '0;
      s1_valid        <= 1'b0;
      s1_last         <= 1'b0;
      s1_draw         <= 1'b0;
      bus.x           <= '0;
      bus.y           <= '0;
      bus.pixel_color <= 1'b0;
      bus.pixel_valid <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      s1_valid <= raster_step;
      s1_last  <= raster_step && last_pix;
      s1_draw  <= raster_step && (state == S_DRAW);
      s1_x     <= cx;
      s1_y     <= cy;
      if (raster_step) begin
        if (cx == 11'(H_PIXELS - 1)) begin
          cx <= '0;
          cy <= last_pix ? 11'd0 : cy + 11'd1;
        end else begin
          cx <= cx + 11'd1;
        end
      end

      bus.x           <= s1_x;
      bus.y           <= s1_y;
      bus.pixel_color <= s1_valid && lit;
      bus.pixel_valid <= s1_valid;
      bus.done        <= s1_last && s1_draw;

      // A fresh tick outranks the COMMIT clear so it is never lost.
      if (state == S_COMMIT) tick_pending <= 1'b0;
      if (state != S_CLEAR) begin
        if (tick_cnt == TW'(TICK_CYCLES - 1)) begin
          tick_cnt     <= '0;
          tick_pending <= 1'b1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end

      if (accept) begin
        hold      <= bus.sample;
        hold_full <= 1'b1;
      end else if (state == S_COMMIT) begin
        hold_full <= 1'b0;
      end

      case (state)
        S_CLEAR, S_DRAW: if (s1_last) state <= S_IDLE;
        S_IDLE:          if (tick_pending) state <= S_COMMIT;
        S_COMMIT: begin
          state <= S_DRAW;
          wptr  <= (wptr == AW'(H_PIXELS - 1)) ? '0 : wptr + 1'b1;
        end
        default:         state <= S_CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_scroll_wave_buffer.sv
// Directed bench for scroll_wave_buffer on an 8x6 screen with a 100-cycle tick.
module tb_scroll_wave_buffer;
  localparam logic [1:0] ST_CLEAR  = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_DRAW   = 2'd3;
`ifdef SCROLL_CENTER_LINE_EN
  localparam logic [7:0] BLANK_COL = 8'h08;
`else
  localparam logic [7:0] BLANK_COL = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         ready_hi_cnt;
  logic [7:0] exp_q [$];
  logic [7:0] col_mask [8];
  int         hv [8];

  scroll_wave_if #(.AMP_WIDTH(31)) bus ();

  scroll_wave_buffer #(
    .H_PIXELS(8), .V_PIXELS(6), .AMP_WIDTH(31), .AMP_SHIFT(1),
    .CLK_HZ(100), .SAMPLES_PER_SEC(1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Rows lit for a column of the given half-height, hand-derived for C=3.
  function automatic logic [7:0] mask_lut(input int h);
    case (h)
      1:       return 8'h0C;
      2:       return 8'h1E;
      3:       return 8'h3F;
      default: return BLANK_COL;
    endcase
  endfunction

  // driver: offer one sample and hold it until accepted
  task automatic send_sample(input logic [30:0] v);
    int n = 0;
    bus.sample       = v;
    bus.sample_valid = 1'b1;
    while (!bus.sample_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val("send_ready", 32'(bus.sample_ready), 1);
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  // monitor: collect one 48-pixel pass into col_mask, checking order and done
  task automatic capture_frame(input string tag, input bit expect_done);
    int n = 0;
    ready_hi_cnt = 0;
    for (int c = 0; c < 8; c++) col_mask[c] = 8'h00;
    while (!bus.pixel_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_start"}, 32'(bus.pixel_valid), 1);
    for (int i = 0; i < 48; i++) begin
      check_val({tag, "_xy"}, {bus.pixel_valid, bus.x, bus.y}, {1'b1, 11'(i % 8), 11'(i / 8)});
      check_val({tag, "_done"}, 32'(bus.done), 32'(expect_done && (i == 47)));
      if (bus.pixel_color) col_mask[bus.x[2:0]][bus.y[2:0]] = 1'b1;
      if (bus.sample_ready && i < 47) ready_hi_cnt++;
      @(negedge clk);
    end
    check_val({tag, "_tail_valid"}, 32'(bus.pixel_valid), 0);
    check_val({tag, "_tail_done"}, 32'(bus.done), 0);
  endtask

  // scoreboard: expected column masks from hv, compared after capture
  task automatic run_frame(input string tag);
    logic [7:0] exp;
    for (int c = 0; c < 8; c++) exp_q.push_back(mask_lut(hv[c]));
    capture_frame(tag, 1'b1);
    for (int c = 0; c < 8; c++) begin
      exp = exp_q.pop_front();
      check_val($sformatf("%s_col%0d", tag, c), 32'(col_mask[c]), 32'(exp));
    end
    check_val({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  task automatic check_clear_pass(input string tag);
    capture_frame(tag, 1'b0);
    for (int c = 0; c < 8; c++)
      check_val($sformatf("%s_col%0d", tag, c), 32'(col_mask[c]), 0);
    check_val({tag, "_ready_during"}, ready_hi_cnt, 0);
    check_val({tag, "_ready_after"}, 32'(bus.sample_ready), 1);
    check_val({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  initial begin
    int n;
    int hi;
    bus.sample       = '0;
    bus.sample_valid = 1'b0;
    reset            = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_pixel_valid", 32'(bus.pixel_valid), 0);
    check_val("rst_done", 32'(bus.done), 0);
    check_val("rst_ready", 32'(bus.sample_ready), 0);
    check_val("rst_xy_color", {bus.x, bus.y, bus.pixel_color}, 0);
    check_val("rst_state", 32'(state_dbg), 32'(ST_CLEAR));
    reset = 1'b0;

    check_clear_pass("clr");

    send_sample(31'd5);
    hv = '{2, 0, 0, 0, 0, 0, 0, 0}; run_frame("f1");
    send_sample(31'd100);
    hv = '{3, 2, 0, 0, 0, 0, 0, 0}; run_frame("f2");
    hv = '{0, 3, 2, 0, 0, 0, 0, 0}; run_frame("f3");
    send_sample(31'd0);
    hv = '{0, 0, 3, 2, 0, 0, 0, 0}; run_frame("f4");
    send_sample(31'd2);
    hv = '{1, 0, 0, 3, 2, 0, 0, 0}; run_frame("f5");
    send_sample(31'd4);
    hv = '{2, 1, 0, 0, 3, 2, 0, 0}; run_frame("f6");
    send_sample(31'd6);
    hv = '{3, 2, 1, 0, 0, 3, 2, 0}; run_frame("f7");
    hv = '{0, 3, 2, 1, 0, 0, 3, 2}; run_frame("f8");
    hv = '{0, 0, 3, 2, 1, 0, 0, 3}; run_frame("f9");

    // valid held high: one accept, ready low until COMMIT empties the register
    bus.sample       = 31'd100;
    bus.sample_valid = 1'b1;
    check_val("hold_rdy_before", 32'(bus.sample_ready), 1);
    @(negedge clk);
    check_val("hold_rdy_after_accept", 32'(bus.sample_ready), 0);
    n  = 0;
    hi = 0;
    while (state_dbg != ST_COMMIT && n < 400) begin
      if (bus.sample_ready) hi++;
      @(negedge clk);
      n++;
    end
    check_val("hold_reach_commit", 32'(state_dbg), 32'(ST_COMMIT));
    check_val("hold_rdy_stuck_low", hi, 0);
    check_val("hold_rdy_in_commit", 32'(bus.sample_ready), 0);
    @(negedge clk);
    check_val("hold_rdy_after_commit", 32'(bus.sample_ready), 1);
    bus.sample = 31'd4;
    @(negedge clk);
    check_val("hold_rdy_second", 32'(bus.sample_ready), 0);
    bus.sample_valid = 1'b0;
    hv = '{3, 0, 0, 3, 2, 1, 0, 0}; run_frame("f10");
    hv = '{2, 3, 0, 0, 3, 2, 1, 0}; run_frame("f11");

    // one-cycle reset in the middle of a DRAW pass
    n = 0;
    while (!bus.pixel_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val("mid_draw_started", 32'(bus.pixel_valid), 1);
    repeat (10) @(negedge clk);
    check_val("mid_draw_state", 32'(state_dbg), 32'(ST_DRAW));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("mid_rst_pv_drop", 32'(bus.pixel_valid), 0);
    check_val("mid_rst_state", 32'(state_dbg), 32'(ST_CLEAR));
    check_val("mid_rst_ready", 32'(bus.sample_ready), 0);
    check_val("mid_rst_done", 32'(bus.done), 0);
    check_clear_pass("clr2");
    hv = '{0, 0, 0, 0, 0, 0, 0, 0}; run_frame("f12");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/scroll_wave_buffer.md
Name: scroll_wave_buffer

Overview:
- Parametrised scrolling amplitude display for the VGA pixel writer.
- Accepts one amplitude sample per animation tick through a valid/ready handshake and scales it to a column half-height.
- Stores column heights in a circular column memory rather than a full bitmap, so scrolling needs no per-row shifting.
- After each tick, rasterises the full screen with the newest column at x=0, then pulses done.

Parameters:
- H_PIXELS, 640, screen width in pixels and column memory depth.
- V_PIXELS, 480, screen height in pixels; must be even.
- AMP_WIDTH, 31, sample width in bits.
- AMP_SHIFT, 20, right shift applied to a sample before clamping.
- CLK_HZ, 50000000, clock frequency.
- SAMPLES_PER_SEC, 10, animation ticks per second; TICK_CYCLES = CLK_HZ / SAMPLES_PER_SEC.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sample  in  AMP_WIDTH  amplitude value, unsigned.
- sample_valid  in  1  sample is offered.
- sample_ready  out  1  sample holding register is empty.
- x  out  11  pixel column.
- y  out  11  pixel row.
- pixel_color  out  1  1 = white, 0 = black.
- pixel_valid  out  1  x, y and pixel_color form a write this cycle.
- done  out  1  one-cycle pulse when a frame pass completes.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset values:
  - x=0, y=0, pixel_color=0, pixel_valid=0, done=0, sample_ready=0.
  - Write pointer wptr=0, tick counter=0, tick_pending=0, holding register empty.
  - State = CLEAR.
- Reset asserted in any state, including mid-frame, aborts the current pass within the same cycle.
- States:
  - CLEAR: writes 0 to column entry x on row 0 of the pass. Emits pixel_color=0 for every (x,y), raster order x fastest, H_PIXELS*V_PIXELS cycles. No done pulse. Then goes to IDLE and sample_ready rises.
  - IDLE: on tick_pending, go to COMMIT.
  - COMMIT: one cycle. mem[wptr] <= half of the held sample (0 if none is held); clear the holding register; wptr <= (wptr+1) mod H_PIXELS; clear tick_pending; go to DRAW.
  - DRAW: raster over all pixels, H_PIXELS*V_PIXELS pixel_valid cycles, plus 1 cycle of read latency at the start. The last pixel is output together with done=1. Then go to IDLE.
- Scaling: half = min(sample >> AMP_SHIFT, V_PIXELS/2), computed at COMMIT.
- Pixel rule, with C = V_PIXELS/2:
  - Column shown at screen x is mem[(wptr-1-x) mod H_PIXELS].
  - The pixel is lit iff half>0 and C-half <= y <= C+half-1.
- Read pipeline: memory read is registered. x, y, pixel_color and pixel_valid are registered together and always mutually aligned.
- Tick counter:
  - Free-runs from the end of CLEAR.
  - On reaching TICK_CYCLES-1 it wraps to 0 and sets tick_pending.
  - A tick arriving while tick_pending is already set is dropped; there is at most one pending tick.
  - A tick during DRAW is served right after DRAW.
- Handshake:
  - The transfer happens on a cycle with sample_valid and sample_ready both high.
  - sample_ready = holding register empty and state != CLEAR.
  - A sample accepted in the same cycle as COMMIT goes into the next column; COMMIT consumes only a sample that was already held.
- Wrap-around: wptr wraps at H_PIXELS. The oldest column is overwritten and scrolls off at x=H_PIXELS-1.

Optional Feature:
- SCROLL_CENTER_LINE_EN defined: in DRAW, row y=C is lit in every column regardless of height, giving a visible zero axis. CLEAR is unchanged.
- Undefined: a column with half=0 is fully black.

Test Plan:
All scenarios use H_PIXELS=8, V_PIXELS=6, AMP_SHIFT=1, CLK_HZ=100, SAMPLES_PER_SEC=1. This gives TICK_CYCLES=100 and C=3.
- Reset then idle -> 48 consecutive pixel_valid cycles, all pixel_color=0, raster order (0,0)..(7,5); sample_ready rises after them; done stays 0.
- Send sample=5 before the first tick -> in DRAW, column x=0 has rows 1..4 lit (half=2), all other pixels 0, done pulses once with pixel (7,5).
- Send sample=100 -> half clamps to 3 and rows 0..5 are lit at x=0. Send sample=0, or no sample -> column fully black; with SCROLL_CENTER_LINE_EN, only row 3 lit in every column.
- Send samples 2, 4, 6 on three successive ticks -> frame 3 shows x=0 rows 0..5, x=1 rows 1..4, x=2 rows 2..3. After 9 ticks, the first column has scrolled off.
- Hold sample_valid high with no ticks -> the first sample is accepted and sample_ready stays 0 until COMMIT, then one more sample is accepted.
- Assert reset for 1 cycle mid-DRAW -> pixel_valid drops next cycle, a 48-cycle CLEAR restarts from (0,0), and the column memory reads all zero afterwards.
